// File: rtl/swd_gate_ctrl.sv
// SWD probe gate: keeps SWCLK/SWDIO disconnected until a 4-byte key arrives,
// locks out repeated bad attempts and relocks when the probe goes quiet.
module swd_gate_ctrl #(
   parameter logic [31:0] KEY            = 32'hA5C3_5A3C,
   parameter int          IDLE_CYCLES    = 1000,
   parameter int          GAP_CYCLES     = 100,
   parameter int          LOCKOUT_CYCLES = 500,
   parameter int          MAX_FAILS      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       code_valid,
   input  logic [7:0] code_byte,
   input  logic       lock_req,
   input  logic       swclk_in,
   output logic       enable,
   output logic       led_status,
   output logic       locked_out,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_LOCKED    = 2'd0,
      ST_RECEIVING = 2'd1,
      ST_UNLOCKED  = 2'd2,
      ST_LOCKOUT   = 2'd3
   } state_t;

   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);

   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCKOUT_CYCLES);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

   // Byte 0 of the key sits in the most significant byte.
   function automatic logic [7:0] key_byte(input logic [1:0] idx);
      return KEY[8*(3-int'(idx)) +: 8];
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic                mismatch_q, mismatch_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [LOCK_W-1:0]   lockout_cnt_q, lockout_cnt_d;
   logic                enable_q, enable_d;
   logic                locked_out_q, locked_out_d;
   logic                sync1_q, sync2_q, sync3_q;

   logic                swclk_rise;
   logic                byte_bad;
   logic                relock;
   logic                key_done;
   logic                key_ok;
   logic                gap_expire;
   logic                attempt_fail;
   logic                fail_limit;
   logic                idle_expire;
   logic                lockout_done;
   logic [FAIL_W-1:0]   fail_inc;

   // Two-flop synchronizer plus an edge register for the probe clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= swclk_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign swclk_rise = sync2_q & ~sync3_q;

   always_comb begin
      byte_bad     = (code_byte != key_byte(idx_q));
      fail_inc     = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
      relock       = lock_req && (state_q != ST_LOCKOUT);
      key_done     = (state_q == ST_RECEIVING) && code_valid && !lock_req && (idx_q == 2'd3);
      key_ok       = key_done && !mismatch_q && !byte_bad;
      gap_expire   = (state_q == ST_RECEIVING) && !code_valid && !lock_req &&
                     (gap_cnt_q == GAP_LAST);
      attempt_fail = (key_done && !key_ok) || gap_expire;
      fail_limit   = (fail_inc >= FAIL_MAX);
      idle_expire  = (state_q == ST_UNLOCKED) && !lock_req && !swclk_rise &&
                     (idle_cnt_q == IDLE_LAST);
      lockout_done = (state_q == ST_LOCKOUT) && (lockout_cnt_q == LOCK_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOCKED: begin
            if (!lock_req && code_valid) state_d = ST_RECEIVING;
         end
         ST_RECEIVING: begin
            if (relock)            state_d = ST_LOCKED;
            else if (key_ok)       state_d = ST_UNLOCKED;
            else if (attempt_fail) state_d = fail_limit ? ST_LOCKOUT : ST_LOCKED;
         end
         ST_UNLOCKED: begin
            if (relock || idle_expire) state_d = ST_LOCKED;
         end
         ST_LOCKOUT: begin
            if (lockout_done) state_d = ST_LOCKED;
         end
         default: state_d = ST_LOCKED;
      endcase
   end

   // Key progress only lives while receiving; leaving that state discards it.
   always_comb begin
      idx_d         = 2'd0;
      mismatch_d    = 1'b0;
      gap_cnt_d     = '0;
      idle_cnt_d    = '0;
      lockout_cnt_d = '0;
      fail_cnt_d    = fail_cnt_q;

      if (state_d == ST_RECEIVING) begin
         if (code_valid) begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = mismatch_q | byte_bad;
         end else begin
            idx_d      = idx_q;
            mismatch_d = mismatch_q;
            gap_cnt_d  = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
         end
      end

      if ((state_q == ST_UNLOCKED) && (state_d == ST_UNLOCKED) && !swclk_rise) begin
         idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
      end

      if ((state_q == ST_LOCKOUT) && (state_d == ST_LOCKOUT)) begin
         lockout_cnt_d = (lockout_cnt_q == LOCK_MAX) ? lockout_cnt_q : lockout_cnt_q + 1'b1;
      end

      if (key_ok || lockout_done) begin
         fail_cnt_d = '0;
      end else if (attempt_fail) begin
         fail_cnt_d = fail_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= 2'd0;
         mismatch_q    <= 1'b0;
         fail_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         idle_cnt_q    <= '0;
         lockout_cnt_q <= '0;
      end else begin
         idx_q         <= idx_d;
         mismatch_q    <= mismatch_d;
         fail_cnt_q    <= fail_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         lockout_cnt_q <= lockout_cnt_d;
      end
   end

   // Outputs are registered from the next state so they change with state_o.
   always_comb begin
      enable_d     = (state_d == ST_UNLOCKED);
      locked_out_d = (state_d == ST_LOCKOUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q     <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         enable_q     <= enable_d;
         locked_out_q <= locked_out_d;
      end
   end

   assign enable     = enable_q;
   assign led_status = enable_q;
   assign locked_out = locked_out_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_swd_gate_ctrl.sv
// Bench for swd_gate_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level model of the gate.
module tb_swd_gate_ctrl;

   localparam int IDLE    = 1000;
   localparam int GAP     = 100;
   localparam int LOCKOUT = 500;
   localparam int MAXF    = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code_byte = 8'h00;
   logic       lock_req = 1'b0;
   logic       swclk_in = 1'b0;
   logic       enable, led_status, locked_out;
   logic [1:0] state_o;

   int    errors = 0;
   int    checks = 0;
   string phase = "reset";
   logic  sw = 1'b0;

   logic [7:0] key_seq [4] = '{8'hA5, 8'hC3, 8'h5A, 8'h3C};

   // Model: 0 locked, 1 receiving, 2 unlocked, 3 lockout.
   int         m_mode, m_quiet, m_idle, m_fails, m_pen;
   logic [7:0] m_rx[$];
   logic       m_hist[$];

   swd_gate_ctrl #(
      .KEY(32'hA5C3_5A3C), .IDLE_CYCLES(IDLE), .GAP_CYCLES(GAP),
      .LOCKOUT_CYCLES(LOCKOUT), .MAX_FAILS(MAXF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_byte(code_byte),
      .lock_req(lock_req), .swclk_in(swclk_in), .enable(enable),
      .led_status(led_status), .locked_out(locked_out), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_quiet = 0; m_idle = 0; m_fails = 0; m_pen = 0;
      m_rx.delete();
      m_hist = '{1'b0, 1'b0, 1'b0};
   endtask

   function automatic bit rx_is_key();
      for (int i = 0; i < 4; i++) if (m_rx[i] != key_seq[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_fail();
      m_fails++;
      m_rx.delete();
      if (m_fails >= MAXF) begin m_mode = 3; m_pen = 0; end
      else m_mode = 0;
   endtask

   // A probe edge becomes visible two clk edges after it is sampled.
   task automatic model_step(input logic cv, input logic [7:0] b, input logic lr, input logic s);
      bit rise;
      rise = m_hist[1] && !m_hist[0];
      if (m_mode == 3) begin
         m_pen++;
         if (m_pen == LOCKOUT) begin m_mode = 0; m_fails = 0; end
      end else if (lr) begin
         m_mode = 0;
         m_rx.delete();
      end else if (m_mode == 0) begin
         if (cv) begin m_rx.delete(); m_rx.push_back(b); m_quiet = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
         if (cv) begin
            m_rx.push_back(b);
            m_quiet = 0;
            if (m_rx.size() == 4) begin
               if (rx_is_key()) begin m_mode = 2; m_fails = 0; m_idle = 0; m_rx.delete(); end
               else model_fail();
            end
         end else begin
            m_quiet++;
            if (m_quiet == GAP) model_fail();
         end
      end else begin
         if (rise) m_idle = 0;
         else m_idle++;
         if (m_idle == IDLE) m_mode = 0;
      end
      m_hist.push_back(s);
      void'(m_hist.pop_front());
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: got %0h want %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("state_o", 32'(state_o), m_mode);
      chk("enable", 32'(enable), 32'(m_mode == 2));
      chk("led_status", 32'(led_status), 32'(m_mode == 2));
      chk("locked_out", 32'(locked_out), 32'(m_mode == 3));
   endtask

   task automatic tick(input logic cv, input logic [7:0] b, input logic lr);
      code_valid = cv; code_byte = b; lock_req = lr; swclk_in = sw;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(cv, b, lr, sw);
      #1;
      code_valid = 1'b0; lock_req = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic lr_last);
      tick(1'b1, a, 1'b0);
      tick(1'b1, b, 1'b0);
      tick(1'b1, c, 1'b0);
      tick(1'b1, d, lr_last);
   endtask

   task automatic wait_lockout_end();
      for (int i = 0; i < LOCKOUT + 50 && locked_out; i++) idle(1);
      chk("lockout_exit", 32'(locked_out), 0);
   endtask

   initial begin
      int         lo;
      logic       cv, lr;
      logic [7:0] b;
      int         idx;

      model_reset();
      phase = "reset";
      idle(3);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_enable", 32'(enable), 0);
      chk("rst_locked_out", 32'(locked_out), 0);
      rst_n = 1'b1;
      idle(2);

      phase = "unlock";
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      chk("unlock_enable", 32'(enable), 1);
      chk("unlock_state", 32'(state_o), 2);

      phase = "keepalive";
      for (int i = 0; i < 6; i++) begin idle(200); sw = ~sw; end
      chk("alive_enable", 32'(enable), 1);
      idle(1000);
      chk("idle_enable", 32'(enable), 0);
      chk("idle_state", 32'(state_o), 0);

      phase = "idle_exact";
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      idle(IDLE - 1);
      chk("idle_before", 32'(enable), 1);
      idle(1);
      chk("idle_at", 32'(enable), 0);

      phase = "lockout";
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      chk("bad1_state", 32'(state_o), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      chk("bad2_state", 32'(state_o), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      chk("bad3_locked_out", 32'(locked_out), 1);
      lo = 1;
      for (int i = 0; i < LOCKOUT + 100 && locked_out; i++) begin
         if (i < 4) tick(1'b1, key_seq[i], 1'b0);
         else if (i == 10) tick(1'b0, 8'h00, 1'b1);
         else idle(1);
         if (locked_out) lo++;
      end
      chk("lockout_len", lo, LOCKOUT);
      chk("after_lockout_state", 32'(state_o), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      chk("post_lockout_unlock", 32'(enable), 1);
      tick(1'b0, 8'h00, 1'b1);
      chk("lock_req_relock", 32'(state_o), 0);

      phase = "gap";
      tick(1'b1, 8'hA5, 1'b0);
      tick(1'b1, 8'hC3, 1'b0);
      idle(GAP - 1);
      chk("gap_before", 32'(state_o), 1);
      idle(1);
      chk("gap_timeout", 32'(state_o), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      chk("gap_counted", 32'(locked_out), 1);
      wait_lockout_end();
      tick(1'b1, 8'hA5, 1'b0);
      tick(1'b1, 8'hC3, 1'b0);
      idle(GAP);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      chk("gap_then_unlock", 32'(enable), 1);
      tick(1'b0, 8'h00, 1'b1);

      phase = "lockreq_final";
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b1);
      chk("lr_final_enable", 32'(enable), 0);
      chk("lr_final_state", 32'(state_o), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h00, 1'b0);
      chk("lr_no_fail", 32'(locked_out), 0);
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      chk("lr_then_unlock", 32'(enable), 1);

      phase = "async_reset";
      #2 rst_n = 1'b0;
      #1;
      chk("arst_enable", 32'(enable), 0);
      chk("arst_led", 32'(led_status), 0);
      chk("arst_state", 32'(state_o), 0);
      idle(1);
      rst_n = 1'b1;
      idle(1);
      chk("arst_release_state", 32'(state_o), 0);
      tick(1'b1, 8'hA5, 1'b0);
      tick(1'b1, 8'hC3, 1'b0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      send4(8'hA5, 8'hC3, 8'h5A, 8'h3C, 1'b0);
      chk("rst_midkey_unlock", 32'(enable), 1);
      tick(1'b0, 8'h00, 1'b1);

      phase = "random";
      for (int seg = 0; seg < 40; seg++) begin
         for (int i = 0; i < 60; i++) begin
            cv  = ($urandom_range(0, 2) == 0);
            idx = (m_mode == 1) ? m_rx.size() : 0;
            b   = ($urandom_range(0, 3) != 0) ? key_seq[idx] : 8'($urandom_range(0, 255));
            lr  = ($urandom_range(0, 199) == 0);
            if ((seg % 2 == 0) && ($urandom_range(0, 49) == 0)) sw = ~sw;
            tick(cv, b, lr);
         end
         idle($urandom_range(0, 150));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/swd_gate_ctrl.md
SWD_GATE_CTRL -- requirements
Module: swd_gate_ctrl

Interface
REQ-001 SHALL have parameter KEY, default 32'hA5C3_5A3C, 4-byte unlock key, byte 0 = KEY[31:24].
REQ-002 SHALL have parameter IDLE_CYCLES, default 1000, SWCLK inactivity cycles before auto-relock.
REQ-003 SHALL have parameter GAP_CYCLES, default 100, maximum clk cycles between key bytes.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 500, penalty duration after MAX_FAILS failures.
REQ-005 SHALL have parameter MAX_FAILS, default 3, consecutive failed attempts that trigger lockout.
REQ-006 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port code_valid, input, 1, one-cycle strobe qualifying code_byte.
REQ-009 SHALL have port code_byte, input, 8, key byte from the upstream receiver.
REQ-010 SHALL have port lock_req, input, 1, synchronous force-relock request.
REQ-011 SHALL have port swclk_in, input, 1, raw probe SWCLK, asynchronous to clk.
REQ-012 SHALL have port enable, output, 1, passthrough gate; 1 = SWCLK/SWDIO connected.
REQ-013 SHALL have port led_status, output, 1, equals enable.
REQ-014 SHALL have port locked_out, output, 1, high while in LOCKOUT.
REQ-015 SHALL have port state_o, output, 2, LOCKED=0, RECEIVING=1, UNLOCKED=2, LOCKOUT=3.

Function
REQ-016 SHALL implement FSM states LOCKED, RECEIVING, UNLOCKED, LOCKOUT; enable registered, 1 only in UNLOCKED.
REQ-017 LOCKED: code_valid SHALL compare byte 0, set byte index to 1, go RECEIVING.
REQ-018 RECEIVING: each code_valid SHALL compare the byte at the current index against KEY and OR any difference into a sticky mismatch flag; no early abort on mismatch.
REQ-019 On the 4th byte: all matched SHALL go UNLOCKED and clear fail count; enable high the cycle after the 4th strobe.
REQ-020 On the 4th byte with mismatch: fail count SHALL increment; at MAX_FAILS go LOCKOUT, else LOCKED.
REQ-021 RECEIVING with no code_valid for GAP_CYCLES consecutive cycles SHALL count as a failed attempt per REQ-020.
REQ-022 UNLOCKED: idle counter SHALL clear on each detected SWCLK rising edge; at IDLE_CYCLES go LOCKED.
REQ-023 swclk_in SHALL pass through a 2-flop synchronizer plus edge register; a rising edge is detected within 3 clk cycles.
REQ-024 code_valid in UNLOCKED or LOCKOUT SHALL be ignored; no counter or state change.
REQ-025 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then go LOCKED with fail count cleared.
REQ-026 lock_req in any state except LOCKOUT SHALL go LOCKED next cycle, discard partial key, and not count a failure.
REQ-027 lock_req coincident with the final matching byte SHALL win: LOCKED, enable stays 0.
REQ-028 lock_req in LOCKOUT SHALL be ignored; lockout is never shortened.
REQ-029 Counters SHALL be sized to $clog2(param+1) and saturate; none wraps.

Reset
REQ-030 rst_n low SHALL immediately force LOCKED, enable=0, led_status=0, locked_out=0, state_o=0, and clear all counters, index, mismatch flag, and synchronizer flops.
REQ-031 Reset asserted mid-key or mid-lockout SHALL abandon the operation; after release, the block accepts a fresh key.

Verification
REQ-032 Bytes A5,C3,5A,3C on consecutive strobes -> enable=1 the cycle after the 4th strobe, state_o=2.
REQ-033 Unlocked, no SWCLK edges for 1000 cycles -> enable=0, state_o=0; SWCLK toggling every 200 cycles -> enable stays 1.
REQ-034 Three wrong 4-byte keys (A5,C3,5A,00) -> locked_out=1 for 500 cycles, correct key ignored meanwhile, then LOCKED and accepts the correct key.
REQ-035 Two bytes, then 100 idle cycles -> back to LOCKED, fail count 1; the correct key then unlocks.
REQ-036 lock_req asserted with the 4th correct byte -> enable stays 0, state_o=0, no failure counted.
REQ-037 rst_n pulsed low while UNLOCKED -> enable=0 asynchronously, state_o=0 after release.
